// File: rtl/mac_pkg.sv
// Shared types and helpers for the pipelined MAC bank.
//   drain_st_e : drain FSM states
//   sat_res_t  : result of sat_add (clamped sum + overflow flag)
//   sat_add    : signed add clamped to an acc_w-bit range (acc_w <= 64)
//   Def*       : default parameter values
package mac_pkg;

  localparam int unsigned DefW          = 8;
  localparam int unsigned DefAccW       = 32;
  localparam int unsigned DefNumIn      = 3;
  localparam int unsigned DefNumAcc     = 8;
  localparam int unsigned DefClrOnDrain = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrain
  } drain_st_e;

  typedef struct packed {
    logic signed [63:0] sum;
    logic               ovf;
  } sat_res_t;

  // Operands are sign-extended acc_w-bit values; the 65-bit sum cannot wrap, so comparing it
  // against the acc_w-bit limits is exact.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        acc_w);
    sat_res_t           res;
    logic signed [64:0] full;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    full    = {a[63], a} + {b[63], b};
    hi      = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo      = -(65'sd1 <<< (acc_w - 1));
    res.sum = full[63:0];
    res.ovf = 1'b0;
    if (full > hi) begin
      res.sum = hi[63:0];
      res.ovf = 1'b1;
    end else if (full < lo) begin
      res.sum = lo[63:0];
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_bank_pipe_if.sv
// Bundles the MAC request, result and drain handshake signals of mac_bank_pipe.
//   master : the side that issues requests and consumes results/drain data
//   slave  : the MAC bank itself
interface mac_bank_pipe_if #(
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_ACC = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_ACC);

  logic                  clear;
  logic [NUM_IN-1:0]     in_valid;
  logic                  weight_valid;
  logic [SEL_W-1:0]      acc_sel;
  logic [NUM_IN*W-1:0]   a_in;
  logic [W-1:0]          weight;
  logic [NUM_IN*W-1:0]   a_out;
  logic [ACC_W-1:0]      acc_out;
  logic                  valid_out;
  logic                  drain_start;
  logic                  drain_valid;
  logic                  drain_ready;
  logic [SEL_W-1:0]      drain_idx;
  logic [ACC_W-1:0]      drain_data;
  logic                  busy;
  logic                  ovf;

  modport master (
    output clear, in_valid, weight_valid, acc_sel, a_in, weight, drain_start, drain_ready,
    input  a_out, acc_out, valid_out, drain_valid, drain_idx, drain_data, busy, ovf
  );

  modport slave (
    input  clear, in_valid, weight_valid, acc_sel, a_in, weight, drain_start, drain_ready,
    output a_out, acc_out, valid_out, drain_valid, drain_idx, drain_data, busy, ovf
  );

endinterface

// File: rtl/mac_drain_fsm.sv
// Drain sequencer for the accumulator bank: IDLE -> WAIT -> DRAIN -> IDLE.
//   clk, rst           : clock, synchronous active-high reset
//   clear_i            : abort drain, return to IDLE
//   drain_start_i      : begin readout (ignored unless IDLE)
//   pipe_empty_next_i  : no MAC will be in flight after this edge
//   drain_ready_i      : consumer accepts the presented cell
//   drain_valid_o      : a cell is being presented
//   drain_idx_o        : index of presented cell
//   busy_o             : FSM not IDLE
//   accept_o           : drain handshake completes this cycle
module mac_drain_fsm
  import mac_pkg::*;
#(
  parameter int unsigned NUM_ACC = DefNumAcc
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       drain_start_i,
  input  logic                       pipe_empty_next_i,
  input  logic                       drain_ready_i,
  output logic                       drain_valid_o,
  output logic [$clog2(NUM_ACC)-1:0] drain_idx_o,
  output logic                       busy_o,
  output logic                       accept_o
);
  localparam int unsigned SEL_W = $clog2(NUM_ACC);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_ACC - 1);

  drain_st_e        state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             drain_valid_q, busy_q;

  assign accept_o = drain_valid_q & drain_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (drain_start_i) state_d = StWait;
      // Requests are refused outside IDLE, so the pipe empties within one WAIT cycle.
      StWait: if (pipe_empty_next_i) begin
        state_d = StDrain;
        idx_d   = '0;
      end
      StDrain: if (accept_o) begin
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      state_d = StIdle;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      drain_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      drain_valid_q <= (state_d == StDrain);
      busy_q        <= (state_d != StIdle);
    end
  end

  assign drain_valid_o = drain_valid_q;
  assign drain_idx_o   = idx_q;
  assign busy_o        = busy_q;

endmodule

// File: rtl/mac_bank_pipe.sv
// Pipelined MAC into a bank of NUM_ACC accumulators with a handshaked bank drain.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mac_bank_pipe_if.slave (requests, acc_out/valid_out, drain handshake, ovf)
// Stage 1 registers the selected activation times the gated weight; stage 2 does the
// single-cycle read-modify-write of the target cell.
// Build option MAC_SAT_EN: stage-2 sums saturate and set the sticky ovf flag; otherwise
// sums wrap and ovf stays 0.
module mac_bank_pipe
  import mac_pkg::*;
#(
  parameter int unsigned W            = DefW,
  parameter int unsigned ACC_W        = DefAccW,   // >= 2*W, <= 64
  parameter int unsigned NUM_IN       = DefNumIn,
  parameter int unsigned NUM_ACC      = DefNumAcc, // >= 2
  parameter int unsigned CLR_ON_DRAIN = DefClrOnDrain
) (
  input logic            clk,
  input logic            rst,
  mac_bank_pipe_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_ACC);
  localparam int unsigned PW    = 2 * W;

  logic [NUM_IN*W-1:0]     a_out_q;
  logic                    p1_valid_q, p1_valid_d;
  logic [SEL_W-1:0]        p1_sel_q, p1_sel_d;
  logic signed [ACC_W-1:0] p1_prod_q, p1_prod_d;
  logic signed [ACC_W-1:0] acc_q [NUM_ACC];
  logic signed [ACC_W-1:0] acc_d [NUM_ACC];
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    valid_out_q, valid_out_d;
  logic                    ovf_q, ovf_d;

  logic signed [W-1:0]     act_sel, w_gated;
  logic signed [PW-1:0]    prod;
  logic                    req_hit, sel_ok;
  logic signed [ACC_W-1:0] cell_cur, sum;
  logic                    sum_ovf;
  logic                    busy, drain_acc;
  logic [SEL_W-1:0]        drain_idx;
`ifdef MAC_SAT_EN
  sat_res_t                sat;
`endif

  mac_drain_fsm #(
    .NUM_ACC (NUM_ACC)
  ) u_drain_fsm (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (bus.clear),
    .drain_start_i     (bus.drain_start),
    .pipe_empty_next_i (~p1_valid_d),
    .drain_ready_i     (bus.drain_ready),
    .drain_valid_o     (bus.drain_valid),
    .drain_idx_o       (drain_idx),
    .busy_o            (busy),
    .accept_o          (drain_acc)
  );

  // Lowest set in_valid bit wins: scan from the top so the lowest match is written last.
  always_comb begin
    act_sel = '0;
    req_hit = 1'b0;
    for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
      if (bus.in_valid[k]) begin
        act_sel = bus.a_in[k*W +: W];
        req_hit = 1'b1;
      end
    end
  end

  // Stage 1
  always_comb begin
    w_gated    = bus.weight_valid ? bus.weight : '0;
    prod       = PW'(act_sel) * PW'(w_gated);
    sel_ok     = (32'(bus.acc_sel) < NUM_ACC);
    p1_valid_d = req_hit & sel_ok & ~busy & ~bus.clear;
    p1_sel_d   = bus.acc_sel;
    p1_prod_d  = ACC_W'(prod);
  end

  // Stage 2 adder
  always_comb begin
    cell_cur = acc_q[p1_sel_q];
`ifdef MAC_SAT_EN
    sat      = sat_add(64'(cell_cur), 64'(p1_prod_q), ACC_W);
    sum      = sat.sum[ACC_W-1:0];
    sum_ovf  = sat.ovf;
`else
    sum      = cell_cur + p1_prod_q;
    sum_ovf  = 1'b0;
`endif
  end

  // Bank and result registers; later assignments take priority.
  always_comb begin
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    valid_out_d = p1_valid_q;
    ovf_d       = ovf_q | (p1_valid_q & sum_ovf);
    if (drain_acc && (CLR_ON_DRAIN != 0)) acc_d[drain_idx] = '0;
    if (p1_valid_q) begin
      acc_d[p1_sel_q] = sum;
      acc_out_d       = sum;
    end
    if (bus.clear) begin
      for (int i = 0; i < int'(NUM_ACC); i++) acc_d[i] = '0;
      acc_out_d   = '0;
      valid_out_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_q  <= 1'b0;
      p1_sel_q    <= '0;
      p1_prod_q   <= '0;
      acc_q       <= '{default: '0};
      acc_out_q   <= '0;
      valid_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      p1_valid_q  <= p1_valid_d;
      p1_sel_q    <= p1_sel_d;
      p1_prod_q   <= p1_prod_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      valid_out_q <= valid_out_d;
      ovf_q       <= ovf_d;
    end
  end

  // Pass-through chain is deliberately not reset.
  always_ff @(posedge clk) begin
    a_out_q <= bus.a_in;
  end

  assign bus.a_out      = a_out_q;
  assign bus.acc_out    = acc_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.drain_idx  = drain_idx;
  assign bus.drain_data = acc_q[drain_idx];
  assign bus.busy       = busy;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_mac_bank_pipe.sv
// Self-checking bench for mac_bank_pipe (W=8, ACC_W=16, NUM_IN=3, NUM_ACC=4, CLR_ON_DRAIN=1).
// A cycle-level reference model predicts each acc_out/valid_out two cycles after a request.
module tb_mac_bank_pipe;
  localparam int unsigned W       = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned NUM_IN  = 3;
  localparam int unsigned NUM_ACC = 4;
  localparam int unsigned CLR     = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_bank_pipe_if #(.W(W), .ACC_W(ACC_W), .NUM_IN(NUM_IN), .NUM_ACC(NUM_ACC)) bus ();

  mac_bank_pipe #(
    .W            (W),
    .ACC_W        (ACC_W),
    .NUM_IN       (NUM_IN),
    .NUM_ACC      (NUM_ACC),
    .CLR_ON_DRAIN (CLR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_cell [NUM_ACC] = '{default: 0};
  bit m_busy = 1'b0;
  bit m_ovf  = 1'b0;
  bit exp_v  [4] = '{default: 1'b0};
  int exp_val[4] = '{default: 0};

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bring an exact sum into the accumulator range (clamp or wrap).
  function automatic int fix(input int s);
    int lim = 1 << (ACC_W - 1);
`ifdef MAC_SAT_EN
    if (s > lim - 1) begin m_ovf = 1'b1; return lim - 1; end
    if (s < -lim) begin m_ovf = 1'b1; return -lim; end
    return s;
`else
    return (((s + lim) % (2 * lim)) + 2 * lim) % (2 * lim) - lim;
`endif
  endfunction

  task automatic set_req(input logic [2:0] iv, input logic wv, input int sel,
                         input int a0, input int a1, input int a2, input int w);
    bus.in_valid     = iv;
    bus.weight_valid = wv;
    bus.acc_sel      = 2'(sel);
    bus.a_in         = {8'(a2), 8'(a1), 8'(a0)};
    bus.weight       = 8'(w);
  endtask

  // Apply the model to the inputs now presented, advance one clock, check MAC outputs.
  task automatic step();
    logic [NUM_IN*W-1:0] a_snap;
    logic [W-1:0]        act;
    bit                  hit;
    int                  slot, a_i, w_i, sel;
    a_snap = bus.a_in;
    if (rst || bus.clear) begin
      m_cell = '{default: 0};
      exp_v  = '{default: 1'b0};
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      hit = 1'b0;
      act = '0;
      for (int k = 0; k < int'(NUM_IN); k++) begin
        if (!hit && bus.in_valid[k]) begin
          act = bus.a_in[k*W +: W];
          hit = 1'b1;
        end
      end
      if (hit && !m_busy && int'(bus.acc_sel) < int'(NUM_ACC)) begin
        a_i  = int'($signed(act));
        w_i  = bus.weight_valid ? int'($signed(bus.weight)) : 0;
        sel  = int'(bus.acc_sel);
        m_cell[sel]   = fix(m_cell[sel] + a_i * w_i);
        slot          = (cyc + 2) % 4;
        exp_v[slot]   = 1'b1;
        exp_val[slot] = m_cell[sel];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    slot = cyc % 4;
    chk("valid_out", bus.valid_out, exp_v[slot]);
    if (exp_v[slot]) chk("acc_out", $signed(bus.acc_out), exp_val[slot]);
    exp_v[slot] = 1'b0;
    chk("a_out", bus.a_out, a_snap);
  endtask

  task automatic idle(input int n);
    bus.in_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Full drain; hold randomly deasserts ready, inject issues a request during WAIT.
  task automatic do_drain(input bit hold, input bit inject);
    bus.drain_start = 1'b1;
    step();
    bus.drain_start = 1'b0;
    bus.in_valid    = '0;
    m_busy          = 1'b1;
    chk("busy_wait", bus.busy, 1);
    chk("dv_wait", bus.drain_valid, 0);
    if (inject) set_req(3'b001, 1'b1, 0, 100, 0, 0, 1);
    step();
    bus.in_valid = '0;
    for (int i = 0; i < int'(NUM_ACC); i++) begin
      chk("drain_valid", bus.drain_valid, 1);
      chk("drain_idx", bus.drain_idx, i);
      chk("drain_data", $signed(bus.drain_data), m_cell[i]);
      if (hold && $urandom_range(0, 1) == 1) begin
        bus.drain_ready = 1'b0;
        step();
        chk("hold_valid", bus.drain_valid, 1);
        chk("hold_idx", bus.drain_idx, i);
        chk("hold_data", $signed(bus.drain_data), m_cell[i]);
      end
      bus.drain_ready = 1'b1;
      step();
      if (CLR != 0) m_cell[i] = 0;
    end
    bus.drain_ready = 1'b0;
    m_busy          = 1'b0;
    chk("busy_done", bus.busy, 0);
    chk("dv_done", bus.drain_valid, 0);
  endtask

  initial begin
    bus.clear       = 1'b0;
    bus.drain_start = 1'b0;
    bus.drain_ready = 1'b0;
    set_req(3'b000, 1'b1, 0, 0, 0, 0, 0);

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_acc_out", bus.acc_out, 0);
    chk("rst_drain_valid", bus.drain_valid, 0);
    chk("rst_drain_idx", bus.drain_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    do_drain(1'b0, 1'b0);

    // Back-to-back to one cell
    set_req(3'b001, 1'b1, 1, 3, 0, 0, -4);
    step(); step(); step();
    idle(2);
    chk("b2b_final", $signed(bus.acc_out), -36);

    // Lowest-bit priority and weight gating
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    set_req(3'b110, 1'b1, 0, 0, 5, 9, 2);
    step();
    idle(2);
    chk("prio_acc", $signed(bus.acc_out), 10);
    set_req(3'b110, 1'b0, 0, 0, 5, 9, 2);
    step();
    idle(2);
    chk("gated_acc", $signed(bus.acc_out), 10);

    // Drain handshake; last load coincides with drain_start, a request during WAIT is dropped
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    set_req(3'b001, 1'b1, 0, 5, 0, 0, 1);
    step();
    set_req(3'b001, 1'b1, 2, -7, 0, 0, 1);
    step();
    set_req(3'b001, 1'b1, 3, 9, 0, 0, 1);
    do_drain(1'b1, 1'b1);
    do_drain(1'b0, 1'b0);

    // Saturation / wrap
    set_req(3'b001, 1'b1, 2, 127, 0, 0, 127);
    step(); step(); step();
    idle(2);
`ifdef MAC_SAT_EN
    chk("sat_third", $signed(bus.acc_out), 32767);
    chk("sat_ovf", bus.ovf, 1);
`else
    chk("wrap_third", $signed(bus.acc_out), -17149);
    chk("wrap_ovf", bus.ovf, 0);
`endif

    // Clear at the second drain accept
    set_req(3'b001, 1'b1, 1, 7, 0, 0, 3);
    step();
    idle(2);
    bus.drain_start = 1'b1;
    step();
    bus.drain_start = 1'b0;
    m_busy          = 1'b1;
    step();
    bus.drain_ready = 1'b1;
    step();
    m_cell[0]       = 0;
    chk("clr_idx1", bus.drain_idx, 1);
    bus.clear       = 1'b1;
    step();
    bus.clear       = 1'b0;
    bus.drain_ready = 1'b0;
    chk("clr_dv", bus.drain_valid, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_ovf", bus.ovf, 0);
    do_drain(1'b0, 1'b0);

    // Randomised traffic against the model
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, NUM_ACC - 1)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)));
      bus.clear = ($urandom_range(0, 31) == 0);
      step();
    end
    bus.clear = 1'b0;
    idle(2);
    chk("rand_ovf", bus.ovf, m_ovf);
    do_drain(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
